datamem_responder: RTL and testbench

Memory-side responder for the data-memory control path of the pipelined CPU. It accepts the `ReadMem`/`MemWr` requests launched by the memory-stage pipeline register, services them against an internal byte-addressed store with a programmable wait latency, and returns read data with a one-cycle valid strobe. While a request is outstanding it holds the pipeline with `stall`. It also flags illegal requests.

---
 rtl/datamem_pkg.sv | 17 +
 rtl/datamem_array.sv | 29 ++
 rtl/datamem_responder.sv | 131 +++++++++++++
 tb/tb_datamem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/datamem_pkg.sv
// Shared types and constants for the data-memory responder.
package datamem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dm_state_t;

  localparam logic [3:0] XFER_DWORD = 4'd8;
  localparam logic [3:0] XFER_BYTE  = 4'd1;

  function automatic logic [7:0] lane_mask(input logic is_byte, input logic [2:0] lane);
    return is_byte ? (8'd1 << lane) : 8'hFF;
  endfunction

endpackage

// File: rtl/datamem_array.sv
// Single-port 64-bit word store with per-byte write enables and a registered read.
module datamem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [7:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 8; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/datamem_responder.sv
// Memory-side responder: accepts one load/store, waits LATENCY cycles, then responds.
//
// state | meaning
// IDLE  | waiting for ReadMem/MemWr; request latched on accept
// WAIT  | counting down the programmed latency, pipeline stalled
// RESP  | read data valid / write commits at the closing edge
module datamem_responder
  import datamem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReadMem,
  input  logic        MemWr,
  input  logic [63:0] address,
  input  logic [63:0] wr_data,
  input  logic [3:0]  xfer_size,
  output logic [63:0] rd_data,
  output logic        rd_valid,
  output logic        stall,
  output logic        err
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  dm_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_rd_q, op_wr_q, is_byte_q, illegal_q;
  logic [2:0]       lane_q;
  logic [AW-1:0]    idx_q;
  logic [63:0]      wdata_q;
  logic             rd_valid_q, err_q;

  logic             req, illegal_in, in_idle, enter_resp, cur_rd, cur_illegal;
  logic             arr_re, arr_we;
  logic [AW-1:0]    arr_addr;
  logic [63:0]      arr_rdata, arr_wdata;
  logic [7:0]       rd_byte;

  assign req     = ReadMem | MemWr;
  assign in_idle = (state_q == IDLE);

  assign illegal_in = (ReadMem & MemWr)
                    | ((xfer_size != XFER_DWORD) && (xfer_size != XFER_BYTE))
                    | ((xfer_size == XFER_DWORD) && (address[2:0] != 3'd0))
                    | (address[63:3] >= 61'(DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = LAT_C;
          state_d = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero latency RESP is entered straight from IDLE, before the latch is loaded.
  assign enter_resp  = (state_d == RESP);
  assign cur_rd      = in_idle ? ReadMem    : op_rd_q;
  assign cur_illegal = in_idle ? illegal_in : illegal_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_rd_q    <= 1'b0;
      op_wr_q    <= 1'b0;
      is_byte_q  <= 1'b0;
      illegal_q  <= 1'b0;
      lane_q     <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= enter_resp & cur_rd;
      if (enter_resp & cur_illegal) err_q <= 1'b1;
      if (in_idle && req) begin
        op_rd_q   <= ReadMem;
        op_wr_q   <= MemWr;
        is_byte_q <= (xfer_size == XFER_BYTE);
        illegal_q <= illegal_in;
        lane_q    <= address[2:0];
        idx_q     <= address[AW+2:3];
        wdata_q   <= wr_data;
      end
    end
  end

  assign arr_re    = enter_resp & cur_rd & ~cur_illegal;
  assign arr_we    = (state_q == RESP) & op_wr_q & ~illegal_q;
  assign arr_addr  = in_idle ? address[AW+2:3] : idx_q;
  assign arr_wdata = is_byte_q ? {8{wdata_q[7:0]}} : wdata_q;

  datamem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .re_i    (arr_re),
    .we_i    (arr_we),
    .be_i    (lane_mask(is_byte_q, lane_q)),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  assign rd_byte  = arr_rdata[{lane_q, 3'b000} +: 8];
  assign rd_data  = ((state_q == RESP) && op_rd_q && !illegal_q)
                  ? (is_byte_q ? {56'd0, rd_byte} : arr_rdata) : '0;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign stall    = reset & ((in_idle & req) | (state_q == WAIT));

endmodule

// File: tb/tb_datamem_responder.sv
// Scoreboard bench for datamem_responder at LATENCY=2 and LATENCY=0.
module tb_datamem_responder;

  localparam int PERIOD = 10;

  logic clk = 1'b0;
  logic reset;
  always #(PERIOD/2) clk = ~clk;

  logic        rm2, wr2, rm0, wr0;
  logic [63:0] addr2, wd2, addr0, wd0;
  logic [3:0]  sz2, sz0;
  logic [63:0] rdd2, rdd0;
  logic        rv2, st2, er2, rv0, st0, er0;

  datamem_responder #(.DEPTH(1024), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .ReadMem(rm2), .MemWr(wr2), .address(addr2),
    .wr_data(wd2), .xfer_size(sz2), .rd_data(rdd2), .rd_valid(rv2),
    .stall(st2), .err(er2)
  );

  datamem_responder #(.DEPTH(1024), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .ReadMem(rm0), .MemWr(wr0), .address(addr0),
    .wr_data(wd0), .xfer_size(sz0), .rd_data(rdd0), .rd_valid(rv0),
    .stall(st0), .err(er0)
  );

  int          sel = 1;
  logic [63:0] o_rd_data;
  logic        o_rd_valid, o_stall, o_err;
  assign o_rd_data  = (sel != 0) ? rdd2 : rdd0;
  assign o_rd_valid = (sel != 0) ? rv2  : rv0;
  assign o_stall    = (sel != 0) ? st2  : st0;
  assign o_err      = (sel != 0) ? er2  : er0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] mdl [2][64];
  logic        err_exp [2];
  logic [63:0] sb_q [$];
  time         resp_time;

  task automatic clear_inputs(input int d);
    if (d != 0) begin
      rm2 = 0; wr2 = 0; addr2 = '0; wd2 = '0; sz2 = '0;
    end else begin
      rm0 = 0; wr0 = 0; addr0 = '0; wd0 = '0; sz0 = '0;
    end
  endtask

  // Called when the DUT is at the start of an IDLE cycle; returns at the start of the next one.
  task automatic req(input int d, input logic rm, input logic wr, input logic [63:0] addr,
                     input logic [63:0] data, input logic [3:0] sz);
    int lat, stalls, w, lane;
    logic ill;
    bit done, early;
    logic [63:0] exp, t;
    lat  = (d != 0) ? 2 : 0;
    sel  = d;
    ill  = (rm && wr) || (sz != 4'd1 && sz != 4'd8) || (sz == 4'd8 && addr[2:0] != 3'd0)
         || (addr[63:3] >= 61'd1024);
    w    = int'(addr[8:3]);
    lane = int'(addr[2:0]);
    if (ill) begin
      err_exp[d] = 1'b1;
      if (rm) sb_q.push_back(64'd0);
    end else if (wr) begin
      t = mdl[d][w];
      if (sz == 4'd8) t = data;
      else t[8*lane +: 8] = data[7:0];
      mdl[d][w] = t;
    end else begin
      t = mdl[d][w];
      exp = (sz == 4'd8) ? t : {56'd0, t[8*lane +: 8]};
      sb_q.push_back(exp);
    end
    if (d != 0) begin
      rm2 = rm; wr2 = wr; addr2 = addr; wd2 = data; sz2 = sz;
    end else begin
      rm0 = rm; wr0 = wr; addr0 = addr; wd0 = data; sz0 = sz;
    end
    #1;
    n_checks++;
    if (o_stall !== 1'b1) begin
      n_errors++; $display("FAIL stall_accept addr=%h: got %b expected 1", addr, o_stall);
    end
    stalls = 1; done = 0; early = 0;
    for (int c = 1; c <= lat + 4 && !done; c++) begin
      @(posedge clk); #1;
      if (o_stall === 1'b1) begin
        stalls++;
        if (o_rd_valid !== 1'b0) early = 1;
      end else begin
        done = 1;
        resp_time = $time;
        n_checks++;
        if (c != lat + 1) begin
          n_errors++; $display("FAIL resp_cycle addr=%h: got %0d expected %0d", addr, c, lat + 1);
        end
        n_checks++;
        if (stalls != lat + 1) begin
          n_errors++; $display("FAIL stall_cycles addr=%h: got %0d expected %0d", addr, stalls, lat + 1);
        end
        n_checks++;
        if (o_rd_valid !== rm) begin
          n_errors++; $display("FAIL rd_valid addr=%h: got %b expected %b", addr, o_rd_valid, rm);
          if (rm && sb_q.size() > 0) void'(sb_q.pop_front());
        end
        if (o_rd_valid === 1'b1) begin
          n_checks++;
          if (sb_q.size() == 0) begin
            n_errors++; $display("FAIL rd_data addr=%h: got %h expected no read", addr, o_rd_data);
          end else begin
            exp = sb_q.pop_front();
            if (o_rd_data !== exp) begin
              n_errors++; $display("FAIL rd_data addr=%h: got %h expected %h", addr, o_rd_data, exp);
            end
          end
        end
        n_checks++;
        if (o_err !== err_exp[d]) begin
          n_errors++; $display("FAIL err addr=%h: got %b expected %b", addr, o_err, err_exp[d]);
        end
      end
    end
    n_checks++;
    if (!done) begin
      n_errors++; $display("FAIL timeout addr=%h: got no RESP expected cycle %0d", addr, lat + 1);
    end
    n_checks++;
    if (early) begin
      n_errors++; $display("FAIL early_valid addr=%h: got 1 expected 0 before RESP", addr);
    end
    @(posedge clk); #1;
    clear_inputs(d);
  endtask

  task automatic check_outputs_zero(input string tag);
    n_checks++;
    if (o_stall !== 1'b0) begin n_errors++; $display("FAIL %s stall: got %b expected 0", tag, o_stall); end
    n_checks++;
    if (o_rd_valid !== 1'b0) begin n_errors++; $display("FAIL %s rd_valid: got %b expected 0", tag, o_rd_valid); end
    n_checks++;
    if (o_err !== 1'b0) begin n_errors++; $display("FAIL %s err: got %b expected 0", tag, o_err); end
    n_checks++;
    if (o_rd_data !== 64'd0) begin n_errors++; $display("FAIL %s rd_data: got %h expected 0", tag, o_rd_data); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rm2 = 1; wr2 = 0; addr2 = 64'h10; wd2 = '1; sz2 = 4'd8;
    rm0 = 0; wr0 = 1; addr0 = 64'h10; wd0 = '1; sz0 = 4'd8;
    repeat (2) @(posedge clk);
    #1;
    sel = 1; #1; check_outputs_zero("reset_lat2");
    sel = 0; #1; check_outputs_zero("reset_lat0");
    clear_inputs(0); clear_inputs(1);
    err_exp[0] = 0; err_exp[1] = 0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_dword();
    req(1, 0, 1, 64'h10, 64'h1122334455667788, 4'd8);
    req(1, 1, 0, 64'h10, 64'd0, 4'd8);
  endtask

  task automatic test_byte();
    req(1, 0, 1, 64'h13, 64'hAB, 4'd1);
    req(1, 1, 0, 64'h10, 64'd0, 4'd8);
    req(1, 1, 0, 64'h13, 64'd0, 4'd1);
    req(1, 1, 0, 64'h16, 64'd0, 4'd1);
  endtask

  task automatic test_illegal();
    req(1, 1, 0, 64'h0C, 64'd0, 4'd8);
    req(1, 1, 0, 64'h10, 64'd0, 4'd8);
    req(1, 0, 1, 64'h18, 64'h0123456789ABCDEF, 4'd8);
    req(1, 1, 1, 64'h18, 64'hDEADBEEFDEADBEEF, 4'd8);
    req(1, 1, 0, 64'h18, 64'd0, 4'd8);
    req(1, 1, 0, 64'h18, 64'd0, 4'd4);
    req(1, 0, 1, 64'h00, 64'hA5A5A5A5A5A5A5A5, 4'd8);
    req(1, 0, 1, 64'h2000, 64'h5A5A5A5A5A5A5A5A, 4'd8);
    req(1, 1, 0, 64'h00, 64'd0, 4'd8);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      req(1, 0, 1, 64'h100 + 64'(i * 8), {$urandom, $urandom}, 4'd8);
    for (int i = 0; i < 24; i++) begin
      logic [63:0] a;
      logic        is_byte, is_wr;
      is_byte = 1'($urandom_range(0, 1));
      is_wr   = 1'($urandom_range(0, 1));
      a = 64'h100 + 64'($urandom_range(0, 7) * 8);
      if (is_byte) a = a + 64'($urandom_range(0, 7));
      req(1, !is_wr, is_wr, a, {$urandom, $urandom}, is_byte ? 4'd1 : 4'd8);
    end
  endtask

  task automatic test_lat0();
    req(0, 0, 1, 64'h40, 64'hCAFEF00D12345678, 4'd8);
    req(0, 1, 0, 64'h40, 64'd0, 4'd8);
    req(0, 0, 1, 64'h42, 64'h99, 4'd1);
    req(0, 1, 0, 64'h45, 64'd0, 4'd1);
    req(0, 1, 0, 64'h40, 64'd0, 4'd8);
  endtask

  task automatic test_back_to_back();
    time ta, tb;
    req(0, 1, 0, 64'h40, 64'd0, 4'd8); ta = resp_time;
    req(0, 1, 0, 64'h42, 64'd0, 4'd1); tb = resp_time;
    n_checks++;
    if (tb - ta != 2 * PERIOD) begin
      n_errors++; $display("FAIL b2b_lat0 spacing: got %0t expected %0t", tb - ta, 2 * PERIOD);
    end
    req(1, 1, 0, 64'h10, 64'd0, 4'd8); ta = resp_time;
    req(1, 1, 0, 64'h13, 64'd0, 4'd1); tb = resp_time;
    n_checks++;
    if (tb - ta != 4 * PERIOD) begin
      n_errors++; $display("FAIL b2b_lat2 spacing: got %0t expected %0t", tb - ta, 4 * PERIOD);
    end
  endtask

  task automatic test_reset_mid();
    req(1, 0, 1, 64'h20, 64'h0F0E0D0C0B0A0908, 4'd8);
    sel = 1;
    rm2 = 0; wr2 = 1; addr2 = 64'h20; wd2 = 64'hFFFFFFFFFFFFFFFF; sz2 = 4'd8;
    @(posedge clk); #1;
    n_checks++;
    if (o_stall !== 1'b1) begin
      n_errors++; $display("FAIL mid_wait stall: got %b expected 1", o_stall);
    end
    #1 reset = 1'b0;
    #1 check_outputs_zero("reset_mid");
    clear_inputs(1);
    err_exp[0] = 0; err_exp[1] = 0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    req(1, 1, 0, 64'h20, 64'd0, 4'd8);
    req(0, 1, 0, 64'h40, 64'd0, 4'd8);
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs(0); clear_inputs(1);
    err_exp[0] = 0; err_exp[1] = 0;
    test_reset();
    test_dword();
    test_byte();
    test_illegal();
    test_random();
    test_lat0();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: got no finish expected finish within %0d cycles", 20000);
    $fatal(1, "watchdog expired");
  end

endmodule
